io_confirm_input: RTL and testbench

//  Input-side MMIO peripheral feeding the CPU's switch/confirm read path. Synchronises and debounces
//  the confirm push-button and 8 switches, captures the switch value on each debounced press, and

---
 rtl/io_confirm_input_pkg.sv | 24 ++
 rtl/io_confirm_input_debounce.sv | 79 +++++++
 rtl/io_confirm_input.sv | 86 ++++++++
 tb/tb_io_confirm_input.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_confirm_input_pkg.sv
// Shared definitions for the confirm/switch MMIO input peripheral:
// register offsets, STATUS bit layout and debounce FSM encodings.
package io_confirm_input_pkg;

    localparam logic [3:0] ADDR_DATA   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;

    localparam int STAT_VALID   = 0;
    localparam int STAT_OVERRUN = 1;

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    function automatic logic [31:0] pack_status(input logic ovr, input logic vld);
        logic [31:0] s;
        s               = '0;
        s[STAT_VALID]   = vld;
        s[STAT_OVERRUN] = ovr;
        return s;
    endfunction

endpackage

// File: rtl/io_confirm_input_debounce.sv
// Push-button synchroniser and debouncer: emits a single-cycle press_pulse
// per accepted press and a stable debounced level.
module io_debounce
    import io_confirm_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press_pulse,
    output logic level
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_reg;
    logic             btn_s;
    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    assign btn_s = sync_reg[1];
    assign level = (state_reg == ST_PRESSED) || (state_reg == ST_RELEASE_WAIT);

    // The pulse is combinational so capture happens on the same edge the FSM leaves PRESS_WAIT.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        press_pulse = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (btn_s) begin
                    state_next = ST_PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!btn_s) begin
                    state_next = ST_IDLE;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next  = ST_PRESSED;
                    press_pulse = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!btn_s) begin
                    state_next = ST_RELEASE_WAIT;
                    cnt_next   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (btn_s) begin
                    state_next = ST_PRESSED;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg  <= '0;
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            sync_reg  <= {sync_reg[0], btn};
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

endmodule

// File: rtl/io_confirm_input.sv
// Confirm/switch MMIO input: captures the synchronised switches on each
// debounced press and holds them with valid/overrun flags until read.
module io_confirm_input
    import io_confirm_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int DATA_W          = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              confirm_btn,
    input  logic [DATA_W-1:0] sw,
    input  logic              rd_data_en,
    input  logic              rd_stat_en,
    output logic [31:0]       rd_data,
    output logic              valid,
    output logic              overrun
);

    logic [DATA_W-1:0] sw_meta_reg, sw_sync_reg;
    logic [DATA_W-1:0] data_reg;
    logic [31:0]       rd_data_reg;
    logic              valid_reg, overrun_reg;
    logic              press_pulse, btn_level;

    io_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .btn        (confirm_btn),
        .press_pulse(press_pulse),
        .level      (btn_level)
    );

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_sw_sync
            always_ff @(posedge clk) begin
                if (rst) begin
                    sw_meta_reg[gi] <= 1'b0;
                    sw_sync_reg[gi] <= 1'b0;
                end else begin
                    sw_meta_reg[gi] <= sw[gi];
                    sw_sync_reg[gi] <= sw_meta_reg[gi];
                end
            end
        end
    endgenerate

    // A DATA read in the press cycle frees the slot, so the new value is taken instead of flagging overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_reg <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            if (rd_data_en) begin
                rd_data_reg <= {{(32-DATA_W){1'b0}}, data_reg};
            end else if (rd_stat_en) begin
                rd_data_reg <= pack_status(overrun_reg, valid_reg);
            end

            if (press_pulse && (!valid_reg || rd_data_en)) begin
                data_reg  <= sw_sync_reg;
                valid_reg <= 1'b1;
            end else if (rd_data_en) begin
                valid_reg <= 1'b0;
            end

            if (press_pulse && valid_reg && !rd_data_en) begin
                overrun_reg <= 1'b1;
            end else if (rd_stat_en && !rd_data_en) begin
                overrun_reg <= 1'b0;
            end

            assert (!(press_pulse && btn_level));
        end
    end

    assign rd_data = rd_data_reg;
    assign valid   = valid_reg;
    assign overrun = overrun_reg;

endmodule

// File: tb/tb_io_confirm_input.sv
// Scoreboard bench for io_confirm_input with a short debounce window.
module tb_io_confirm_input;

    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        confirm_btn;
    logic [7:0]  sw;
    logic        rd_data_en;
    logic        rd_stat_en;
    logic [31:0] rd_data;
    logic        valid;
    logic        overrun;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb_q[$];
    logic [31:0] exp_v;

    io_confirm_input #(
        .DEBOUNCE_CYCLES(DC),
        .DATA_W         (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .confirm_btn(confirm_btn),
        .sw         (sw),
        .rd_data_en (rd_data_en),
        .rd_stat_en (rd_stat_en),
        .rd_data    (rd_data),
        .valid      (valid),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_read(input logic is_data, input logic [31:0] expected);
        sb_q.push_back(expected);
        rd_data_en = is_data;
        rd_stat_en = !is_data;
        tick(1);
        rd_data_en = 1'b0;
        rd_stat_en = 1'b0;
        $display("read %s expect %08h got %08h", is_data ? "DATA  " : "STATUS", expected, rd_data);
    endtask

    task automatic press_release(input logic [7:0] v);
        sw = v;
        tick(3);
        confirm_btn = 1'b1;
        tick(DC + 6);
        confirm_btn = 1'b0;
        tick(DC + 6);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 50; i++) begin
            checks++;
            if (valid !== 1'b0 || overrun !== 1'b0 || rd_data !== 32'h0) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: valid=%b overrun=%b rd_data=%08h, want 0 0 00000000",
                         i, valid, overrun, rd_data);
            end
            tick(1);
        end
    endtask

    task automatic test_hold();
        sw = 8'h3C;
        tick(3);
        confirm_btn = 1'b1;
        tick(6);
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL hold_early: valid=%b want 0", valid); end
        tick(1);
        checks++;
        if (valid !== 1'b1) begin errors++; $display("FAIL hold_latency: valid=%b want 1", valid); end
        drive_read(1'b1, 32'h0000_003C);
        exp_v = sb_q.pop_front();
        checks++;
        if (rd_data !== exp_v || valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_read: rd_data=%08h valid=%b want %08h 0", rd_data, valid, exp_v);
        end
        tick(12);
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL hold_no_retrigger: valid=%b want 0", valid); end
        confirm_btn = 1'b0;
        tick(DC + 6);
    endtask

    task automatic test_glitch();
        logic seen;
        seen = 1'b0;
        sw = 8'h99;
        for (int r = 0; r < 10; r++) begin
            confirm_btn = 1'b1;
            for (int k = 0; k < 2; k++) begin tick(1); seen = seen | valid; end
            confirm_btn = 1'b0;
            for (int k = 0; k < 2; k++) begin tick(1); seen = seen | valid; end
        end
        tick(DC);
        seen = seen | valid;
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL glitch_valid: valid seen=%b want 0", seen); end
        drive_read(1'b0, 32'h0);
        exp_v = sb_q.pop_front();
        checks++;
        if (rd_data !== exp_v) begin errors++; $display("FAIL glitch_status: rd_data=%08h want %08h", rd_data, exp_v); end
    endtask

    task automatic test_overrun();
        press_release(8'hA5);
        checks++;
        if (valid !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_first: valid=%b overrun=%b want 1 0", valid, overrun);
        end
        press_release(8'h11);
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: overrun=%b want 1", overrun); end
        drive_read(1'b0, 32'h3);
        exp_v = sb_q.pop_front();
        checks++;
        if (rd_data !== exp_v) begin errors++; $display("FAIL ovr_status1: rd_data=%08h want %08h", rd_data, exp_v); end
        drive_read(1'b1, 32'hA5);
        exp_v = sb_q.pop_front();
        checks++;
        if (rd_data !== exp_v) begin errors++; $display("FAIL ovr_data: rd_data=%08h want %08h", rd_data, exp_v); end
        drive_read(1'b0, 32'h0);
        exp_v = sb_q.pop_front();
        checks++;
        if (rd_data !== exp_v) begin errors++; $display("FAIL ovr_status2: rd_data=%08h want %08h", rd_data, exp_v); end
    endtask

    task automatic test_press_with_data_read();
        press_release(8'h01);
        sw = 8'h02;
        tick(3);
        confirm_btn = 1'b1;
        tick(6);
        drive_read(1'b1, 32'h01);
        exp_v = sb_q.pop_front();
        checks++;
        if (rd_data !== exp_v || valid !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL coin_data: rd_data=%08h valid=%b overrun=%b want %08h 1 0", rd_data, valid, overrun, exp_v);
        end
        confirm_btn = 1'b0;
        tick(DC + 6);
        drive_read(1'b1, 32'h02);
        exp_v = sb_q.pop_front();
        checks++;
        if (rd_data !== exp_v) begin errors++; $display("FAIL coin_newdata: rd_data=%08h want %08h", rd_data, exp_v); end
        drive_read(1'b0, 32'h0);
        exp_v = sb_q.pop_front();
        checks++;
        if (rd_data !== exp_v) begin errors++; $display("FAIL coin_status: rd_data=%08h want %08h", rd_data, exp_v); end
    endtask

    task automatic test_press_with_stat_read();
        press_release(8'hC3);
        sw = 8'h44;
        tick(3);
        confirm_btn = 1'b1;
        tick(6);
        drive_read(1'b0, 32'h1);
        exp_v = sb_q.pop_front();
        checks++;
        if (rd_data !== exp_v || overrun !== 1'b1) begin
            errors++;
            $display("FAIL coin_stat: rd_data=%08h overrun=%b want %08h 1", rd_data, overrun, exp_v);
        end
        confirm_btn = 1'b0;
        tick(DC + 6);
        drive_read(1'b0, 32'h3);
        exp_v = sb_q.pop_front();
        checks++;
        if (rd_data !== exp_v) begin errors++; $display("FAIL coin_stat_after: rd_data=%08h want %08h", rd_data, exp_v); end
        drive_read(1'b1, 32'hC3);
        exp_v = sb_q.pop_front();
        checks++;
        if (rd_data !== exp_v) begin errors++; $display("FAIL coin_stat_data: rd_data=%08h want %08h", rd_data, exp_v); end
    endtask

    task automatic test_both_strobes();
        press_release(8'h5A);
        press_release(8'h77);
        sb_q.push_back(32'h5A);
        rd_data_en = 1'b1;
        rd_stat_en = 1'b1;
        tick(1);
        rd_data_en = 1'b0;
        rd_stat_en = 1'b0;
        $display("read BOTH   expect %08h got %08h", 32'h5A, rd_data);
        exp_v = sb_q.pop_front();
        checks++;
        if (rd_data !== exp_v || valid !== 1'b0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL both_prio: rd_data=%08h valid=%b overrun=%b want %08h 0 1", rd_data, valid, overrun, exp_v);
        end
        drive_read(1'b0, 32'h2);
        exp_v = sb_q.pop_front();
        checks++;
        if (rd_data !== exp_v) begin errors++; $display("FAIL both_status: rd_data=%08h want %08h", rd_data, exp_v); end
    endtask

    task automatic test_reset_mid_debounce();
        sw = 8'h96;
        tick(3);
        confirm_btn = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        checks++;
        if (rd_data !== 32'h0 || valid !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_state: rd_data=%08h valid=%b overrun=%b want 0 0 0", rd_data, valid, overrun);
        end
        tick(6);
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL mid_reset_early: valid=%b want 0", valid); end
        tick(1);
        checks++;
        if (valid !== 1'b1) begin errors++; $display("FAIL mid_reset_recount: valid=%b want 1", valid); end
        confirm_btn = 1'b0;
        tick(DC + 6);
        drive_read(1'b1, 32'h96);
        exp_v = sb_q.pop_front();
        checks++;
        if (rd_data !== exp_v) begin errors++; $display("FAIL mid_reset_data: rd_data=%08h want %08h", rd_data, exp_v); end
    endtask

    initial begin
        rst         = 1'b1;
        confirm_btn = 1'b0;
        sw          = 8'hFF;
        rd_data_en  = 1'b0;
        rd_stat_en  = 1'b0;
        tick(3);
        rst = 1'b0;
        test_reset();
        test_hold();
        test_glitch();
        test_overrun();
        test_press_with_data_read();
        test_press_with_stat_read();
        test_both_strobes();
        test_reset_mid_debounce();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
